// File: rtl/pwm_source_switch_pkg.sv
// Shared definitions for the PWM audio path: switch FSM states and
// width helpers used by the source selector and the generator wiring.
package pwm_source_switch_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        DRAIN = 2'd1,
        MUTE  = 2'd2
    } sw_state_e;

    // Width of a select bus that encodes mute (0) plus num_src sources.
    function automatic int sel_width(input int num_src);
        if (num_src < 1) begin
            return 1;
        end else begin
            return $clog2(num_src + 1);
        end
    endfunction

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if ($clog2(n) < 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pwm_source_switch.sv
// Click-free PWM audio source selector. A selection change lets the current
// pulse finish (bounded), forces a low gap, then hands over to the new source.
module pwm_source_switch
    import pwm_source_switch_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = sel_width(NUM_SRC),
    parameter int MUTE_CYCLES = 64,
    parameter int MAX_DRAIN   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   audio_select,
    input  logic [NUM_SRC-1:0] pwm_in,
    output logic               pwm_out,
    output logic [SEL_W-1:0]   active_sel,
    output logic               switching
);

    localparam int DRAIN_W = cnt_width(MAX_DRAIN);
    localparam int MUTE_W  = cnt_width(MUTE_CYCLES);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAX_DRAIN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(32'd1);
    localparam logic [MUTE_W-1:0]  MUTE_ONE   = MUTE_W'(32'd1);
    localparam logic [SEL_W-1:0]   SEL_MAX    = SEL_W'(NUM_SRC);
    localparam logic [SEL_W-1:0]   SEL_ZERO   = {SEL_W{1'b0}};

    // The edge that leaves DRAIN already drives the pin low, so it is the
    // first gap cycle; MUTE itself therefore runs MUTE_CYCLES-1 cycles and
    // handover lands exactly MUTE_CYCLES edges after the gap starts.
    localparam int                MUTE_EXIT_I = (MUTE_CYCLES >= 2) ? (MUTE_CYCLES - 2) : 0;
    localparam logic [MUTE_W-1:0] MUTE_LAST   = MUTE_W'(MUTE_EXIT_I);

    sw_state_e          state_r;
    sw_state_e          state_next_s;
    logic [SEL_W-1:0]   active_sel_r;
    logic [SEL_W-1:0]   active_sel_next_s;
    logic               pwm_r;
    logic               pwm_next_s;
    logic               switching_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_cnt_next_s;
    logic [MUTE_W-1:0]  mute_cnt_r;
    logic [MUTE_W-1:0]  mute_cnt_next_s;
    logic [SEL_W-1:0]   nsel_s;
    logic               src_bit_s;

    // Out-of-range selects fall back to mute.
    always_comb begin
        if (audio_select > SEL_MAX) begin
            nsel_s = SEL_ZERO;
        end else begin
            nsel_s = audio_select;
        end
    end

    // Sample of the currently routed source; reads 0 while muted.
    always_comb begin
        src_bit_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_bit_s = src_bit_s | ((active_sel_r == SEL_W'(k + 1)) & pwm_in[k]);
        end
    end

    // Next-state, counter and pin logic of the switch FSM.
    always_comb begin
        state_next_s      = state_r;
        active_sel_next_s = active_sel_r;
        pwm_next_s        = pwm_r;
        drain_cnt_next_s  = drain_cnt_r;
        mute_cnt_next_s   = mute_cnt_r;
        case (state_r)
            PLAY: begin
                pwm_next_s = src_bit_s;
                if (nsel_s != active_sel_r) begin
                    state_next_s     = DRAIN;
                    drain_cnt_next_s = {DRAIN_W{1'b0}};
                end else begin
                    state_next_s = PLAY;
                end
            end
            DRAIN: begin
                if ((active_sel_r == SEL_ZERO) || !src_bit_s || (drain_cnt_r == DRAIN_LAST)) begin
                    pwm_next_s      = 1'b0;
                    mute_cnt_next_s = {MUTE_W{1'b0}};
                    state_next_s    = MUTE;
                end else begin
                    pwm_next_s       = src_bit_s;
                    drain_cnt_next_s = drain_cnt_r + DRAIN_ONE;
                end
            end
            MUTE: begin
                pwm_next_s = 1'b0;
                if (mute_cnt_r >= MUTE_LAST) begin
                    active_sel_next_s = nsel_s;
                    state_next_s      = PLAY;
                end else begin
                    mute_cnt_next_s = mute_cnt_r + MUTE_ONE;
                end
            end
            default: begin
                pwm_next_s   = 1'b0;
                state_next_s = PLAY;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= PLAY;
            active_sel_r <= SEL_ZERO;
            pwm_r        <= 1'b0;
            switching_r  <= 1'b0;
            drain_cnt_r  <= {DRAIN_W{1'b0}};
            mute_cnt_r   <= {MUTE_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            active_sel_r <= active_sel_next_s;
            pwm_r        <= pwm_next_s;
            switching_r  <= (state_next_s != PLAY);
            drain_cnt_r  <= drain_cnt_next_s;
            mute_cnt_r   <= mute_cnt_next_s;
        end
    end

    assign pwm_out    = pwm_r;
    assign active_sel = active_sel_r;
    assign switching  = switching_r;

endmodule

// File: tb/tb_pwm_source_switch.sv
// Directed bench for pwm_source_switch (NUM_SRC=4, MUTE_CYCLES=8, MAX_DRAIN=16).
module tb_pwm_source_switch;

    localparam int NUM_SRC     = 4;
    localparam int MUTE_CYCLES = 8;
    localparam int MAX_DRAIN   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] audio_select;
    logic [3:0] pwm_in;
    logic       pwm_out;
    logic [2:0] active_sel;
    logic       switching;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic [3:0] pin;
        logic       epwm;
        logic [2:0] eact;
        logic       esw;
    } vec_t;

    vec_t vecs[$];

    pwm_source_switch #(
        .NUM_SRC    (NUM_SRC),
        .MUTE_CYCLES(MUTE_CYCLES),
        .MAX_DRAIN  (MAX_DRAIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .audio_select(audio_select),
        .pwm_in      (pwm_in),
        .pwm_out     (pwm_out),
        .active_sel  (active_sel),
        .switching   (switching)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic epwm, input logic [2:0] eact, input logic esw);
        chk({name, "_pwm"}, {7'd0, pwm_out}, {7'd0, epwm});
        chk({name, "_act"}, {5'd0, active_sel}, {5'd0, eact});
        chk({name, "_sw"},  {7'd0, switching}, {7'd0, esw});
    endtask

    function automatic void add(input logic r, input logic [2:0] s, input logic [3:0] p,
                                input logic ep, input logic [2:0] ea, input logic es);
        vec_t v;
        v.rst = r; v.sel = s; v.pin = p; v.epwm = ep; v.eact = ea; v.esw = es;
        vecs.push_back(v);
    endfunction

    // Select changes during the gap: a, b, c applied at gap edges 0, 2, 4.
    task automatic gap_seq(input string name, input logic [2:0] sa, input logic [2:0] sb,
                           input logic [2:0] sc, input logic [2:0] old_act, input logic [2:0] new_act);
        pwm_in = 4'b0000;
        audio_select = sa;
        cyc();
        expect_out({name, "_e0"}, 1'b0, old_act, 1'b1);
        cyc();
        audio_select = sb;
        for (int k = 2; k < 4; k++) begin
            cyc();
            expect_out($sformatf("%s_e%0d", name, k), 1'b0, old_act, 1'b1);
        end
        audio_select = sc;
        for (int k = 4; k < 8; k++) begin
            cyc();
            expect_out($sformatf("%s_e%0d", name, k), 1'b0, old_act, 1'b1);
        end
        cyc();
        expect_out({name, "_end"}, 1'b0, new_act, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        audio_select = 3'd2;
        pwm_in = 4'hF;

        // Reset held three cycles, then the 0->2 switch starts on release.
        for (int k = 0; k < 3; k++) add(1'b1, 3'd2, 4'hF, 1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b0, 3'd2, 4'hF, 1'b0, 3'd0, 1'b1);
        add(1'b0, 3'd2, 4'hF, 1'b0, 3'd2, 1'b0);
        // Play source 2 (bit 1), one-cycle latency.
        add(1'b0, 3'd2, 4'hF, 1'b1, 3'd2, 1'b0);
        add(1'b0, 3'd2, 4'h0, 1'b0, 3'd2, 1'b0);
        add(1'b0, 3'd2, 4'h2, 1'b1, 3'd2, 1'b0);
        add(1'b0, 3'd2, 4'hD, 1'b0, 3'd2, 1'b0);
        add(1'b0, 3'd2, 4'h2, 1'b1, 3'd2, 1'b0);
        // Source low: one-cycle drain, gap, land on mute.
        for (int k = 0; k < 8; k++) add(1'b0, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1);
        add(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
        // Mute to source 3 with bit 2 toggling; pin low for 9 cycles.
        for (int j = 0; j < 15; j++) begin
            logic [3:0] p;
            p = (j % 2 == 1) ? 4'h4 : 4'hB;
            if (j < 8)       add(1'b0, 3'd3, p, 1'b0, 3'd0, 1'b1);
            else if (j == 8) add(1'b0, 3'd3, p, 1'b0, 3'd3, 1'b0);
            else             add(1'b0, 3'd3, p, p[2], 3'd3, 1'b0);
        end

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            audio_select = vecs[i].sel;
            pwm_in = vecs[i].pin;
            cyc();
            expect_out($sformatf("vec%0d", i), vecs[i].epwm, vecs[i].eact, vecs[i].esw);
        end

        // Drain during a pulse: move to source 1 first.
        audio_select = 3'd1;
        pwm_in = 4'b0000;
        repeat (9) cyc();
        expect_out("to_src1", 1'b0, 3'd1, 1'b0);
        pwm_in = 4'b0001;
        cyc();
        expect_out("src1_play", 1'b1, 3'd1, 1'b0);
        audio_select = 3'd2;
        for (int k = 0; k < 5; k++) begin
            cyc();
            expect_out($sformatf("drain_hi%0d", k), 1'b1, 3'd1, 1'b1);
        end
        pwm_in = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            cyc();
            expect_out($sformatf("drain_gap%0d", k), 1'b0, 3'd1, 1'b1);
        end
        cyc();
        expect_out("drain_land", 1'b0, 3'd2, 1'b0);
        pwm_in = 4'b0010;
        cyc();
        expect_out("drain_fwd1", 1'b1, 3'd2, 1'b0);
        pwm_in = 4'b0000;
        cyc();
        expect_out("drain_fwd0", 1'b0, 3'd2, 1'b0);

        // Drain timeout: source 1 stuck high, select 4.
        audio_select = 3'd1;
        pwm_in = 4'b0001;
        repeat (9) cyc();
        expect_out("to_src1b", 1'b0, 3'd1, 1'b0);
        cyc();
        expect_out("stuck_play", 1'b1, 3'd1, 1'b0);
        audio_select = 3'd4;
        for (int k = 0; k < 16; k++) begin
            cyc();
            expect_out($sformatf("tmo_hi%0d", k), 1'b1, 3'd1, 1'b1);
        end
        for (int k = 16; k < 23; k++) begin
            cyc();
            expect_out($sformatf("tmo_gap%0d", k), 1'b0, 3'd1, 1'b1);
        end
        cyc();
        expect_out("tmo_land", 1'b0, 3'd4, 1'b0);
        pwm_in = 4'b1000;
        cyc();
        expect_out("tmo_fwd", 1'b1, 3'd4, 1'b0);

        // Last value wins; out-of-range select means mute.
        gap_seq("lvw_a", 3'd2, 3'd1, 3'd7, 3'd4, 3'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_out($sformatf("lvw_a_hold%0d", k), 1'b0, 3'd0, 1'b0);
        end
        gap_seq("lvw_b", 3'd2, 3'd7, 3'd1, 3'd0, 3'd1);
        pwm_in = 4'b0001;
        cyc();
        expect_out("lvw_b_fwd", 1'b1, 3'd1, 1'b0);

        // Reset in the middle of a switch.
        audio_select = 3'd3;
        cyc();
        expect_out("rmid_e0", 1'b1, 3'd1, 1'b1);
        pwm_in = 4'b0000;
        cyc();
        expect_out("rmid_e1", 1'b0, 3'd1, 1'b1);
        cyc();
        expect_out("rmid_e2", 1'b0, 3'd1, 1'b1);
        rst = 1'b1;
        cyc();
        expect_out("rmid_rst", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        audio_select = 3'd0;
        pwm_in = 4'hF;
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_out($sformatf("rmid_idle%0d", k), 1'b0, 3'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
